// File: rtl/reg_file_pkg.sv
// Shared RV32 register-file types and constants.
package reg_file_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [XLEN-1:0]       xlen_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = 5'd0;
endpackage

// File: rtl/reg_file_if.sv
// Register-file access bus: two read ports and one write port.
interface reg_file_if;
  import reg_file_pkg::*;

  reg_addr_t read_reg1;
  reg_addr_t read_reg2;
  reg_addr_t write_reg;
  xlen_t     write_data;
  logic      write_reg_enable;
  xlen_t     read_data1;
  xlen_t     read_data2;

  modport master (
    output read_reg1, read_reg2, write_reg, write_data, write_reg_enable,
    input  read_data1, read_data2
  );

  modport slave (
    input  read_reg1, read_reg2, write_reg, write_data, write_reg_enable,
    output read_data1, read_data2
  );
endinterface

// File: rtl/reg_file.sv
// RV32 integer register file: 32x32, two combinational read ports with write-through
// bypass, one synchronous write port, x0 hardwired to zero, async active-high reset.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_WIDTH = reg_file_pkg::XLEN,
  parameter int ADDR_WIDTH = reg_file_pkg::REG_ADDR_W,
  parameter int NUM_REGS   = reg_file_pkg::NUM_REGS
) (
  input  logic        clk,
  input  logic        reset,
  reg_file_if.slave   bus
);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                  wr_en_d;

  // Gating on reset here also suppresses the bypass while reset is held.
  assign wr_en_d = bus.write_reg_enable && (bus.write_reg != ZERO_REG) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_d) begin
      regs_q[bus.write_reg] <= bus.write_data;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(
    input logic [ADDR_WIDTH-1:0] idx,
    input logic [DATA_WIDTH-1:0] stored,
    input logic                  wr_en,
    input logic [ADDR_WIDTH-1:0] wr_idx,
    input logic [DATA_WIDTH-1:0] wr_data
  );
    if (idx == '0) begin
      return '0;
    end else if (wr_en && (wr_idx == idx)) begin
      return wr_data;
    end else begin
      return stored;
    end
  endfunction

  assign bus.read_data1 = read_port(bus.read_reg1, regs_q[bus.read_reg1], wr_en_d,
                                    bus.write_reg, bus.write_data);
  assign bus.read_data2 = read_port(bus.read_reg2, regs_q[bus.read_reg2], wr_en_d,
                                    bus.write_reg, bus.write_data);

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
module tb_reg_file;
  import reg_file_pkg::*;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  logic [31:0] exp_mem [32];

  reg_file_if bus ();

  reg_file u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] wr,
                       input logic [31:0] wd, input logic we);
    bus.read_reg1        = r1;
    bus.read_reg2        = r2;
    bus.write_reg        = wr;
    bus.write_data       = wd;
    bus.write_reg_enable = we;
  endtask

  initial begin
    errors = 0;
    checks = 0;

    // Reset with a would-be bypass pending: outputs must still be zero.
    reset = 1'b1;
    drive(5'd3, 5'd3, 5'd3, 32'hA5A5A5A5, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_bypass_rd1", bus.read_data1, 32'h0);
    chk("reset_bypass_rd2", bus.read_data2, 32'h0);

    @(negedge clk);
    reset = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      bus.read_reg1 = 5'(i);
      bus.read_reg2 = 5'(31 - i);
      #1;
      chk("post_reset_rd1", bus.read_data1, 32'h0);
      chk("post_reset_rd2", bus.read_data2, 32'h0);
    end

    // Write then read back on both ports.
    @(negedge clk);
    drive(5'd0, 5'd0, 5'd5, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    drive(5'd5, 5'd5, 5'd5, 32'h0, 1'b0);
    #1;
    chk("x5_rd1", bus.read_data1, 32'hDEADBEEF);
    chk("x5_rd2", bus.read_data2, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    #1;
    chk("x5_stable_rd1", bus.read_data1, 32'hDEADBEEF);
    chk("x5_stable_rd2", bus.read_data2, 32'hDEADBEEF);

    // x0 ignores writes and never bypasses.
    drive(5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1);
    #1;
    chk("x0_pre_edge", bus.read_data1, 32'h0);
    @(negedge clk);
    bus.write_reg_enable = 1'b0;
    #1;
    chk("x0_post_edge", bus.read_data1, 32'h0);

    // Bypass on port 1 only, then after the edge.
    drive(5'd7, 5'd8, 5'd7, 32'h12345678, 1'b1);
    #1;
    chk("bypass_rd1", bus.read_data1, 32'h12345678);
    chk("bypass_rd2_old", bus.read_data2, 32'h0);
    @(posedge clk);
    #1;
    chk("bypass_post_edge_rd1", bus.read_data1, 32'h12345678);
    @(negedge clk);
    bus.write_reg_enable = 1'b0;
    #1;
    chk("x7_stored", bus.read_data1, 32'h12345678);

    // Both ports bypassing the same write; stored x8 differs from bypass value.
    drive(5'd8, 5'd8, 5'd8, 32'h0BADF00D, 1'b1);
    #1;
    chk("dual_bypass_rd1", bus.read_data1, 32'h0BADF00D);
    chk("dual_bypass_rd2", bus.read_data2, 32'h0BADF00D);
    @(negedge clk);
    drive(5'd8, 5'd7, 5'd8, 32'h11111111, 1'b0);
    #1;
    chk("x8_no_bypass_when_disabled", bus.read_data1, 32'h0BADF00D);
    chk("x7_other_port", bus.read_data2, 32'h12345678);

    // Enable low: no state change.
    drive(5'd9, 5'd9, 5'd9, 32'hCAFEF00D, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("x9_enable_low", bus.read_data1, 32'h0);

    // Fill x1..x31 with distinct random values and verify.
    for (int i = 1; i < 32; i++) begin
      exp_mem[i] = ($urandom & 32'hFFFF_FFE0) | 32'(i);
      drive(5'd0, 5'd0, 5'(i), exp_mem[i], 1'b1);
      @(negedge clk);
    end
    bus.write_reg_enable = 1'b0;
    for (int i = 1; i < 32; i++) begin
      bus.read_reg1 = 5'(i);
      bus.read_reg2 = 5'(32 - i);
      #1;
      chk("fill_rd1", bus.read_data1, exp_mem[i]);
      chk("fill_rd2", bus.read_data2, exp_mem[32 - i]);
    end

    // Async reset between edges clears outputs without a clock edge.
    @(negedge clk);
    bus.read_reg1 = 5'd5;
    bus.read_reg2 = 5'd17;
    #1;
    chk("pre_async_rd1", bus.read_data1, exp_mem[5]);
    #1;
    reset = 1'b1;
    #1;
    chk("async_reset_rd1", bus.read_data1, 32'h0);
    chk("async_reset_rd2", bus.read_data2, 32'h0);

    // First rising edge after release performs the write.
    @(negedge clk);
    reset = 1'b0;
    drive(5'd10, 5'd0, 5'd10, 32'h5555AAAA, 1'b1);
    @(negedge clk);
    bus.write_reg_enable = 1'b0;
    #1;
    chk("first_write_after_reset", bus.read_data1, 32'h5555AAAA);
    for (int i = 0; i < 32; i++) begin
      if (i == 10) continue;
      bus.read_reg1 = 5'(i);
      bus.read_reg2 = 5'(i);
      #1;
      chk("post_async_rd1", bus.read_data1, 32'h0);
      chk("post_async_rd2", bus.read_data2, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
